// File: rtl/pid_ctrl_mc_if.sv
// Request/response bundle of the multi-channel PID controller.
interface pid_ctrl_mc_if #(
  parameter int CHW   = 1,
  parameter int DW    = 16,
  parameter int KW    = 8,
  parameter int OUT_W = 17
);
  logic                    pid_en;
  logic [CHW-1:0]          pid_ch;
  logic signed [DW-1:0]    desired_value;
  logic signed [DW-1:0]    current_value;
  logic [KW-1:0]           kp;
  logic [KW-1:0]           ki;
  logic [KW-1:0]           kd;
  logic                    clr;
  logic                    busy;
  logic                    pid_ack;
  logic [CHW-1:0]          ack_ch;
  logic signed [OUT_W-1:0] out;

  modport master (
    output pid_en, pid_ch, desired_value, current_value, kp, ki, kd, clr,
    input  busy, pid_ack, ack_ch, out
  );

  modport slave (
    input  pid_en, pid_ch, desired_value, current_value, kp, ki, kd, clr,
    output busy, pid_ack, ack_ch, out
  );
endinterface

// File: rtl/pid_ctrl_mc.sv
// Time-multiplexed PID controller for CH_NUM loops sharing one datapath (IDLE->ERR->MUL->SUM->ACK).
// Optional macro PID_DEADBAND_EN: errors with |e| <= DEADBAND are treated as zero.
module pid_ctrl_mc #(
  parameter int CH_NUM   = 2,
  parameter int CHW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  parameter int DW       = 16,
  parameter int KW       = 8,
  parameter int FRAC     = 7,
  parameter int I_LIMIT  = 3000,
  parameter int OUT_W    = 17,
  parameter int DEADBAND = 2
) (
  input  logic          clk,
  input  logic          rst,
  pid_ctrl_mc_if.slave  bus
);

  localparam int EW  = DW + 1;
  localparam int DDW = DW + 2;
  localparam int IW  = $clog2(I_LIMIT + 1) + 1;
  localparam int SW  = ((IW > EW) ? IW : EW) + 1;
  localparam int MW  = (IW > DDW) ? IW : DDW;
  localparam int PW  = KW + MW + 4;

  localparam logic signed [SW-1:0] I_MAX = SW'(I_LIMIT);
  localparam logic signed [SW-1:0] I_MIN = -I_MAX;
  localparam logic signed [PW-1:0] O_MAX = (PW'(1) <<< (OUT_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] O_MIN = ~O_MAX;

`ifdef PID_DEADBAND_EN
  localparam logic signed [EW-1:0] DB_MAX = EW'(DEADBAND);
  localparam logic signed [EW-1:0] DB_MIN = -DB_MAX;
`endif

  if ((CH_NUM < 1) || (I_LIMIT < 1) || (DEADBAND < 0)) begin : g_param_check
    $error("pid_ctrl_mc: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MUL  = 3'd2,
    S_SUM  = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  state_t                  state_r;
  logic                    busy_r;
  logic                    ack_r;
  logic [CHW-1:0]          ack_ch_r;
  logic signed [OUT_W-1:0] out_r;

  logic [CHW-1:0]          ch_r;
  logic                    ch_ok_r;
  logic signed [DW-1:0]    des_r;
  logic signed [DW-1:0]    cur_r;
  logic [KW-1:0]           kp_r;
  logic [KW-1:0]           ki_r;
  logic [KW-1:0]           kd_r;
  logic signed [EW-1:0]    e_r;
  logic signed [IW-1:0]    i_new_r;
  logic signed [DDW-1:0]   d_r;
  logic signed [PW-1:0]    pp_r;
  logic signed [PW-1:0]    pi_r;
  logic signed [PW-1:0]    pd_r;
  logic signed [OUT_W-1:0] sat_r;

  logic signed [IW-1:0]    integ_r  [CH_NUM];
  logic signed [EW-1:0]    last_e_r [CH_NUM];

  logic [CHW-1:0]          idx_s;
  logic signed [EW-1:0]    e_raw_s;
  logic signed [EW-1:0]    e_s;
  logic signed [EW-1:0]    le_s;
  logic signed [IW-1:0]    integ_s;
  logic signed [SW-1:0]    i_sum_s;
  logic signed [IW-1:0]    i_new_s;
  logic signed [DDW-1:0]   d_s;
  logic signed [PW-1:0]    pp_s;
  logic signed [PW-1:0]    pi_s;
  logic signed [PW-1:0]    pd_s;
  logic signed [PW-1:0]    sum_s;
  logic signed [PW-1:0]    sh_s;
  logic signed [OUT_W-1:0] sat_s;

  assign bus.busy    = busy_r;
  assign bus.pid_ack = ack_r;
  assign bus.ack_ch  = ack_ch_r;
  assign bus.out     = out_r;

  // Shared arithmetic: error/integral/derivative, products, and shifted-saturated sum.
  always_comb begin
    idx_s   = '0;
    e_raw_s = '0;
    e_s     = '0;
    le_s    = '0;
    integ_s = '0;
    i_sum_s = '0;
    i_new_s = '0;
    d_s     = '0;
    pp_s    = '0;
    pi_s    = '0;
    pd_s    = '0;
    sum_s   = '0;
    sh_s    = '0;
    sat_s   = '0;

    // Out-of-range channels read slot 0 but never write it back.
    if (ch_ok_r) begin
      idx_s = ch_r;
    end else begin
      idx_s = '0;
    end
    integ_s = integ_r[idx_s];
    le_s    = last_e_r[idx_s];

    e_raw_s = $signed({des_r[DW-1], des_r}) - $signed({cur_r[DW-1], cur_r});
`ifdef PID_DEADBAND_EN
    if ((e_raw_s >= DB_MIN) && (e_raw_s <= DB_MAX)) begin
      e_s = '0;
    end else begin
      e_s = e_raw_s;
    end
`else
    e_s = e_raw_s;
`endif

    i_sum_s = $signed({{(SW-IW){integ_s[IW-1]}}, integ_s}) + $signed({{(SW-EW){e_s[EW-1]}}, e_s});
    if (i_sum_s > I_MAX) begin
      i_new_s = I_MAX[IW-1:0];
    end else if (i_sum_s < I_MIN) begin
      i_new_s = I_MIN[IW-1:0];
    end else begin
      i_new_s = i_sum_s[IW-1:0];
    end
    d_s = $signed({e_s[EW-1], e_s}) - $signed({le_s[EW-1], le_s});

    // Gains are unsigned: zero-extend before the signed multiply.
    pp_s = $signed({{(PW-KW){1'b0}}, kp_r}) * $signed({{(PW-EW){e_r[EW-1]}}, e_r});
    pi_s = $signed({{(PW-KW){1'b0}}, ki_r}) * $signed({{(PW-IW){i_new_r[IW-1]}}, i_new_r});
    pd_s = $signed({{(PW-KW){1'b0}}, kd_r}) * $signed({{(PW-DDW){d_r[DDW-1]}}, d_r});

    sum_s = pp_r + pi_r + pd_r;
    sh_s  = sum_s >>> FRAC;
    if (sh_s > O_MAX) begin
      sat_s = O_MAX[OUT_W-1:0];
    end else if (sh_s < O_MIN) begin
      sat_s = O_MIN[OUT_W-1:0];
    end else begin
      sat_s = sh_s[OUT_W-1:0];
    end
  end

  // Control FSM with pipeline registers, per-channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      busy_r   <= 1'b0;
      ack_r    <= 1'b0;
      ack_ch_r <= '0;
      out_r    <= '0;
      ch_r     <= '0;
      ch_ok_r  <= 1'b0;
      des_r    <= '0;
      cur_r    <= '0;
      kp_r     <= '0;
      ki_r     <= '0;
      kd_r     <= '0;
      e_r      <= '0;
      i_new_r  <= '0;
      d_r      <= '0;
      pp_r     <= '0;
      pi_r     <= '0;
      pd_r     <= '0;
      sat_r    <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        integ_r[i]  <= '0;
        last_e_r[i] <= '0;
      end
    end else if (bus.clr) begin
      // Clear wins over a new request and aborts any operation in flight; out is held.
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        integ_r[i]  <= '0;
        last_e_r[i] <= '0;
      end
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.pid_en) begin
            ch_r    <= bus.pid_ch;
            ch_ok_r <= (int'(bus.pid_ch) < CH_NUM);
            des_r   <= bus.desired_value;
            cur_r   <= bus.current_value;
            kp_r    <= bus.kp;
            ki_r    <= bus.ki;
            kd_r    <= bus.kd;
            busy_r  <= 1'b1;
            state_r <= S_ERR;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_ERR: begin
          e_r     <= e_s;
          i_new_r <= i_new_s;
          d_r     <= d_s;
          state_r <= S_MUL;
        end
        S_MUL: begin
          pp_r    <= pp_s;
          pi_r    <= pi_s;
          pd_r    <= pd_s;
          state_r <= S_SUM;
        end
        S_SUM: begin
          sat_r   <= sat_s;
          state_r <= S_ACK;
        end
        S_ACK: begin
          ack_r    <= 1'b1;
          ack_ch_r <= ch_r;
          if (ch_ok_r) begin
            out_r           <= sat_r;
            integ_r[idx_s]  <= i_new_r;
            last_e_r[idx_s] <= e_r;
          end else begin
            out_r <= '0;
          end
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_ctrl_mc.sv
// Directed self-checking bench for pid_ctrl_mc; expected values are hand-computed.
module tb_pid_ctrl_mc;
  localparam int CHW   = 1;
  localparam int DW    = 16;
  localparam int KW    = 8;
  localparam int OUT_W = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pid_ctrl_mc_if #(.CHW(CHW), .DW(DW), .KW(KW), .OUT_W(OUT_W)) bus ();

  pid_ctrl_mc #(
    .CH_NUM(2), .CHW(CHW), .DW(DW), .KW(KW), .FRAC(7),
    .I_LIMIT(3000), .OUT_W(OUT_W), .DEADBAND(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int ch, input int des, input int cur, input int kp, input int ki, input int kd);
    bus.pid_ch        = CHW'(ch);
    bus.desired_value = DW'(des);
    bus.current_value = DW'(cur);
    bus.kp            = KW'(kp);
    bus.ki            = KW'(ki);
    bus.kd            = KW'(kd);
  endtask

  // Issue one request; lat = cycles from acceptance to ack (-1 if none within 8), bn = busy samples.
  task automatic run_req(input int ch, input int des, input int cur, input int kp, input int ki, input int kd,
                         output longint o, output int lat, output int ach, output int bn);
    set_req(ch, des, cur, kp, ki, kd);
    bus.pid_en = 1'b1;
    tick();
    bus.pid_en = 1'b0;
    set_req(1 - ch, 999, -999, 255, 255, 255);
    lat = -1;
    bn  = bus.busy ? 1 : 0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      tick();
      if (bus.busy) bn++;
      if (bus.pid_ack) lat = k;
    end
    o   = bus.out;
    ach = int'(bus.ack_ch);
  endtask

  task automatic req_chk(input string tag, input int ch, input int des, input int cur,
                         input int kp, input int ki, input int kd, input longint exp_out);
    longint o;
    int lat, ach, bn;
    run_req(ch, des, cur, kp, ki, kd, o, lat, ach, bn);
    check_val({tag, "_lat"}, lat, 4);
    check_val({tag, "_ch"}, ach, ch);
    check_val({tag, "_out"}, o, exp_out);
  endtask

  task automatic count_acks(input int n_cycles, output int n);
    n = 0;
    for (int k = 0; k < n_cycles; k++) begin
      tick();
      if (bus.pid_ack) n++;
    end
  endtask

  initial begin
    longint o;
    int lat, ach, bn, n;
    bus.pid_en = 1'b0;
    bus.clr    = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    do_reset();

    check_val("rst_busy", bus.busy, 0);
    check_val("rst_ack", bus.pid_ack, 0);
    check_val("rst_ack_ch", bus.ack_ch, 0);
    check_val("rst_out", bus.out, 0);

    // Proportional only: 128*60 >>> 7 = 60.
    run_req(0, 100, 40, 128, 0, 0, o, lat, ach, bn);
    check_val("p_lat", lat, 4);
    check_val("p_ch", ach, 0);
    check_val("p_out", o, 60);
    check_val("p_busy_cycles", bn, 5);
    tick();
    check_val("p_ack_pulse", bus.pid_ack, 0);
    check_val("p_busy_clr", bus.busy, 0);
    check_val("p_out_hold", bus.out, 60);

    // Integral clamp on ch1, then ch0 unaffected.
    do_reset();
    req_chk("i1", 1, 2000, 0, 0, 128, 0, 2000);
    req_chk("i2", 1, 2000, 0, 0, 128, 0, 3000);
    req_chk("i3", 1, 2000, 0, 0, 128, 0, 3000);
    req_chk("i_iso", 0, 5, 5, 0, 128, 0, 0);

    // Derivative and clear.
    req_chk("d1", 0, 10, 0, 0, 0, 128, 10);
    req_chk("d2", 0, 30, 0, 0, 0, 128, 20);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    req_chk("d_clr", 0, 30, 0, 0, 0, 128, 30);

    // Saturation and floor rounding.
    req_chk("sat_pos", 0, 32767, -32768, 255, 0, 0, 65535);
    req_chk("sat_neg", 0, -32768, 32767, 255, 0, 0, -65536);
    req_chk("floor", 0, 0, 1, 1, 0, 0, -1);

    // pid_en held high through busy cycles 1-3: exactly one ack.
    set_req(0, 50, 0, 128, 0, 0);
    bus.pid_en = 1'b1;
    n = 0;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 3) bus.pid_en = 1'b0;
      if (bus.pid_ack) n++;
    end
    check_val("hs_acks", n, 1);
    check_val("hs_out", bus.out, 50);
    check_val("hs_busy", bus.busy, 0);

    // Reset at cycle 2 aborts the operation.
    set_req(0, 20, 0, 128, 0, 0);
    bus.pid_en = 1'b1;
    tick();
    bus.pid_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_acks(8, n);
    check_val("rst_mid_acks", n, 0);
    check_val("rst_mid_out", bus.out, 0);
    check_val("rst_mid_busy", bus.busy, 0);

    // clr at cycle 2 aborts, holds out, and wipes last_e.
    req_chk("pre_clr", 0, 7, 0, 128, 0, 0, 7);
    set_req(0, 90, 0, 128, 0, 0);
    bus.pid_en = 1'b1;
    tick();
    bus.pid_en = 1'b0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    count_acks(8, n);
    check_val("clr_mid_acks", n, 0);
    check_val("clr_mid_out", bus.out, 7);
    req_chk("clr_mid_state", 0, 30, 0, 0, 0, 128, 30);

`ifdef PID_DEADBAND_EN
    req_chk("db_e2", 0, 2, 0, 128, 0, 0, 0);
    req_chk("db_e3", 0, 3, 0, 128, 0, 0, 3);
`else
    req_chk("db_e2", 0, 2, 0, 128, 0, 0, 2);
    req_chk("db_e3", 0, 3, 0, 128, 0, 0, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
